ttt_turn_ctrl: RTL and testbench
================================

Name: ttt_turn_ctrl

Overview:
Game sequencer for the tic-tac-toe board storage.
- Accepts the cursor square and the rotary-press pulse, and validates each move against the current board.
- Issues a single-cycle write command to the square-status storage, then alternates the player.
- Detects win and draw, and holds game-over until a new-game request clears the board.
- Sits between the input debounce/cursor logic and the board storage; it feeds the display and status LEDs.

Parameters:
- FIRST_PLAYER, 0: player who moves first after reset (0 = P1, 1 = P2).
- ALT_START, 0: when 1, the first player of each new game alternates relative to the previous game.
- MARK_P1, 2'b01: cell code written for P1.
- MARK_P2, 2'b10: cell code written for P2.

Ports:
- clk, in, 1: system clock.
- clr_n, in, 1: asynchronous active-low reset.
- press, in, 1: debounced single-cycle move-request pulse.
- new_game, in, 1: single-cycle restart request.
- cursor, in, 4: selected square, 1..9 (9 = bottom-right).
- board, in, 18: packed cell codes {sq9..sq1}, 2 bits each; 00 = blank.
- mark_we, out, 1: write strobe to the storage, one cycle wide.
- mark_idx, out, 4: square being written, 1..9.
- mark_val, out, 2: MARK_P1 or MARK_P2.
- board_clr, out, 1: clear-all command to the storage.
- player_turn, out, 1: 0 = P1 to move, 1 = P2 to move.
- move_count, out, 4: legal moves committed this game, 0..9.
- illegal, out, 1: one-cycle pulse when a press is rejected.
- game_over, out, 1: high in GAME_OVER.
- winner, out, 2: 00 = none or draw, 01 = P1, 10 = P2; valid while game_over is high.
- draw, out, 1: high in GAME_OVER when there is no winner.

Behaviour:
- Reset (clr_n low, async) puts the state in CLEAR:
  - player_turn = FIRST_PLAYER; move_count = 0; winner = 00.
  - mark_we, illegal, game_over, draw = 0; mark_idx = 0; mark_val = 00.
  - board_clr = 1 (decoded from CLEAR).
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Storage contract: the storage updates on the rising edge where mark_we = 1 or board_clr = 1.
- States: CLEAR, WAIT_MOVE, COMMIT, EVAL, GAME_OVER.
- CLEAR:
  - board_clr = 1 for exactly one cycle, then go to WAIT_MOVE.
  - Reload player_turn: FIRST_PLAYER, or the inverted previous starter when ALT_START = 1.
  - Reload move_count = 0 and winner = 00.
- WAIT_MOVE, on press:
  - If cursor is in 1..9 and its board cell is 00: latch cursor into mark_idx, set mark_val from player_turn, go to COMMIT.
  - Otherwise: illegal = 1 for the next cycle and stay in WAIT_MOVE.
- COMMIT: mark_we = 1 for this single cycle; move_count increments; go to EVAL.
- EVAL: sample the board, which now includes the new mark. Evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for three equal non-blank codes, in priority order:
  1. Win: winner = that code; go to GAME_OVER.
  2. Else if move_count == 9: draw = 1; go to GAME_OVER.
  3. Else: toggle player_turn; go to WAIT_MOVE.
- GAME_OVER: game_over = 1; press is ignored (no illegal pulse); stays until new_game.
- new_game: in any state it forces the next state to CLEAR. It takes priority over press in the same cycle.
  - A new_game arriving during COMMIT still lets that mark_we cycle complete; CLEAR follows and wipes the board.
- Latency: press to mark_we is 1 cycle. The move result (turn toggle or game_over) is 2 cycles after mark_we rises.
- A press during COMMIT or EVAL is dropped with no illegal pulse.
- move_count saturates at 9 and never wraps.
- The 8-bit cursor bus from the cursor logic is truncated by the integrator. Values 0 and 10..15 are illegal.

Decomposition:
- Shared package ttt_pkg holds:
  - Cell codes: BLANK, MARKER_O / P1, MARKER_X / P2.
  - PLAYER_1 / PLAYER_2.
  - State encoding.
  - The 8 win-line index triples.
- One sub-module, ttt_win_detect: purely combinational. Input is the 18-bit board; outputs are win (1) and win_code (2).

Test Plan:
1. Reset, then P1 presses 1, 5, 9 while P2 presses 2, 3. Expect: mark_we sequence idx 1/01, 2/10, 5/01, 3/10, 9/01; game_over = 1, winner = 01 two cycles after the last mark_we; move_count = 5.
2. Press on occupied square 5, and press with cursor = 0 and cursor = 12. Expect: illegal pulses once each; no mark_we; player_turn unchanged.
3. Draw order 1, 2, 3, 5, 4, 6, 8, 7, 9. Expect: draw = 1, winner = 00, move_count = 9, game_over = 1.
4. In GAME_OVER, press and then new_game in the same cycle. Expect: no illegal pulse; board_clr for one cycle; WAIT_MOVE; move_count = 0. With ALT_START = 1, player_turn inverts relative to the previous game.
5. Assert clr_n low asynchronously mid-COMMIT. Expect: mark_we drops immediately; board_clr = 1; all other outputs at reset values.
6. P2 completes column 3-6-9 (P1 on 1, 2, 4). Expect: winner = 10 and no further player toggle.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game sequencer: cell codes, players,
// FSM encoding and the eight winning lines of the 3x3 board.
package ttt_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t BLANK    = 2'b00;
    localparam cell_t MARKER_O = 2'b01;
    localparam cell_t MARKER_X = 2'b10;
    localparam cell_t CELL_P1  = MARKER_O;
    localparam cell_t CELL_P2  = MARKER_X;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    localparam int          NUM_SQ    = 9;
    localparam int          NUM_LINES = 8;
    localparam int          BOARD_W   = 2 * NUM_SQ;
    localparam logic [3:0]  MAX_MOVES = 4'd9;

    typedef enum logic [2:0] {
        ST_CLEAR     = 3'd0,
        ST_WAIT_MOVE = 3'd1,
        ST_COMMIT    = 3'd2,
        ST_EVAL      = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    // Squares are numbered 1..9, row-major from top-left.
    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd1, 4'd2, 4'd3},
        '{4'd4, 4'd5, 4'd6},
        '{4'd7, 4'd8, 4'd9},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd3, 4'd6, 4'd9},
        '{4'd1, 4'd5, 4'd9},
        '{4'd3, 4'd5, 4'd7}
    };

    function automatic logic sq_valid(input logic [3:0] sq);
        return (sq >= 4'd1) && (sq <= 4'd9);
    endfunction

    // Out-of-range squares read as blank so callers never slice past the board.
    function automatic cell_t cell_at(input logic [BOARD_W-1:0] board, input logic [3:0] sq);
        cell_t c;
        c = BLANK;
        for (int i = 1; i <= NUM_SQ; i++) begin
            if (sq == 4'(i)) begin
                c = board[2*(i-1) +: 2];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ttt_turn_ctrl_if.sv
// Bundle between the cursor/debounce front end, the board storage and the
// game sequencer; the sequencer sits on the slave side.
interface ttt_turn_ctrl_if;

    logic        press;
    logic        new_game;
    logic [3:0]  cursor;
    logic [17:0] board;

    logic        mark_we;
    logic [3:0]  mark_idx;
    logic [1:0]  mark_val;
    logic        board_clr;
    logic        player_turn;
    logic [3:0]  move_count;
    logic        illegal;
    logic        game_over;
    logic [1:0]  winner;
    logic        draw;

    modport master (
        output press, new_game, cursor, board,
        input  mark_we, mark_idx, mark_val, board_clr, player_turn,
               move_count, illegal, game_over, winner, draw
    );

    modport slave (
        input  press, new_game, cursor, board,
        output mark_we, mark_idx, mark_val, board_clr, player_turn,
               move_count, illegal, game_over, winner, draw
    );

endinterface

// File: rtl/ttt_win_detect.sv
// Combinational three-in-a-row detector over the packed 18-bit board.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    output logic               win,
    output cell_t              win_code
);

    cell_t ca;
    cell_t cb;
    cell_t cc;

    // Scan from the last line down so the lowest-numbered line wins a tie.
    always_comb begin
        win      = 1'b0;
        win_code = BLANK;
        ca       = BLANK;
        cb       = BLANK;
        cc       = BLANK;
        for (int l = NUM_LINES - 1; l >= 0; l--) begin
            ca = cell_at(board, WIN_LINES[l][0]);
            cb = cell_at(board, WIN_LINES[l][1]);
            cc = cell_at(board, WIN_LINES[l][2]);
            if ((ca != BLANK) && (ca == cb) && (ca == cc)) begin
                win      = 1'b1;
                win_code = ca;
            end
        end
    end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe game sequencer: validates presses against the board, issues
// one-cycle mark writes, alternates players and detects win/draw.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_CLEAR     | board_clr asserted, per-game registers reloaded
// ST_WAIT_MOVE | waiting for a press; validate cursor against the board
// ST_COMMIT    | mark_we asserted for one cycle, move_count advances
// ST_EVAL      | board now holds the new mark; check win/draw or swap turn
// ST_GAME_OVER | result held; presses ignored until new_game
module ttt_turn_ctrl
    import ttt_pkg::*;
#(
    parameter logic       FIRST_PLAYER = 1'b0,
    parameter logic       ALT_START    = 1'b0,
    parameter logic [1:0] MARK_P1      = 2'b01,
    parameter logic [1:0] MARK_P2      = 2'b10
) (
    input  logic            clk,
    input  logic            clr_n,
    ttt_turn_ctrl_if.slave  bus
);

    state_t      state;
    state_t      state_nxt;

    logic        player_turn_q;
    logic        starter_q;
    logic        fresh_q;
    logic [3:0]  move_count_q;
    cell_t       winner_q;
    logic [3:0]  mark_idx_q;
    cell_t       mark_val_q;
    logic        illegal_q;

    logic        win;
    cell_t       win_code;
    logic        cursor_ok;
    logic        take_move;
    logic        reject;

    ttt_win_detect u_win_detect (
        .board    (bus.board),
        .win      (win),
        .win_code (win_code)
    );

    assign cursor_ok = sq_valid(bus.cursor) && (cell_at(bus.board, bus.cursor) == BLANK);
    assign take_move = (state == ST_WAIT_MOVE) && bus.press && !bus.new_game && cursor_ok;
    assign reject    = (state == ST_WAIT_MOVE) && bus.press && !bus.new_game && !cursor_ok;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR:     state_nxt = ST_WAIT_MOVE;
            ST_WAIT_MOVE: if (take_move) state_nxt = ST_COMMIT;
            ST_COMMIT:    state_nxt = ST_EVAL;
            ST_EVAL: begin
                if (win || (move_count_q == MAX_MOVES)) begin
                    state_nxt = ST_GAME_OVER;
                end else begin
                    state_nxt = ST_WAIT_MOVE;
                end
            end
            ST_GAME_OVER: state_nxt = ST_GAME_OVER;
            default:      state_nxt = ST_CLEAR;
        endcase
        // A pending COMMIT still drives mark_we this cycle; CLEAR then wipes it.
        if (bus.new_game) begin
            state_nxt = ST_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            player_turn_q <= FIRST_PLAYER;
            starter_q     <= FIRST_PLAYER;
            fresh_q       <= 1'b1;
            move_count_q  <= 4'd0;
            winner_q      <= BLANK;
            mark_idx_q    <= 4'd0;
            mark_val_q    <= BLANK;
            illegal_q     <= 1'b0;
        end else begin
            illegal_q <= reject;
            case (state)
                ST_CLEAR: begin
                    fresh_q      <= 1'b0;
                    move_count_q <= 4'd0;
                    winner_q     <= BLANK;
                    // The CLEAR pass right after reset keeps FIRST_PLAYER.
                    if (ALT_START && !fresh_q) begin
                        starter_q     <= ~starter_q;
                        player_turn_q <= ~starter_q;
                    end else begin
                        player_turn_q <= starter_q;
                    end
                end
                ST_WAIT_MOVE: begin
                    if (take_move) begin
                        mark_idx_q <= bus.cursor;
                        mark_val_q <= (player_turn_q == PLAYER_2) ? MARK_P2 : MARK_P1;
                    end
                end
                ST_COMMIT: begin
                    if (move_count_q != MAX_MOVES) begin
                        move_count_q <= move_count_q + 4'd1;
                    end
                end
                ST_EVAL: begin
                    if (!bus.new_game) begin
                        if (win) begin
                            winner_q <= win_code;
                        end else if (move_count_q != MAX_MOVES) begin
                            player_turn_q <= ~player_turn_q;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mark_we     = (state == ST_COMMIT);
    assign bus.board_clr   = (state == ST_CLEAR);
    assign bus.game_over   = (state == ST_GAME_OVER);
    assign bus.draw        = (state == ST_GAME_OVER) && (winner_q == BLANK);
    assign bus.mark_idx    = mark_idx_q;
    assign bus.mark_val    = mark_val_q;
    assign bus.player_turn = player_turn_q;
    assign bus.move_count  = move_count_q;
    assign bus.illegal     = illegal_q;
    assign bus.winner      = winner_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Scoreboard bench for ttt_turn_ctrl: a board-level game model predicts mark
// writes, rejections and results; a negedge monitor pops and compares them.
module tb_ttt_turn_ctrl;

    localparam bit FP  = 1'b0;
    localparam bit ALT = 1'b1;

    localparam int K_MARK = 0;
    localparam int K_ILL  = 1;
    localparam int K_OVER = 2;

    typedef struct {
        int kind;
        int idx;
        int val;
        int win;
        int drw;
        int cnt;
        int turn;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    ttt_turn_ctrl_if bus();

    ttt_turn_ctrl #(
        .FIRST_PLAYER (FP),
        .ALT_START    (ALT),
        .MARK_P1      (2'b01),
        .MARK_P2      (2'b10)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    // Board storage as seen by the sequencer.
    logic [17:0] store;
    always @(posedge clk) begin
        if (bus.board_clr) store <= '0;
        else if (bus.mark_we && bus.mark_idx >= 4'd1 && bus.mark_idx <= 4'd9)
            store[2*(int'(bus.mark_idx)-1) +: 2] <= bus.mark_val;
    end
    assign bus.board = store;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;
    exp_t q[$];

    int m_board[1:9];
    bit m_turn;
    bit m_starter;
    bit m_over;
    int m_count;

    task automatic check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(int k, int idx, int val, int win, int drw, int cnt, int turn, int cy);
        exp_t e;
        e.kind = k; e.idx = idx; e.val = val; e.win = win;
        e.drw = drw; e.cnt = cnt; e.turn = turn; e.cyc = cy;
        q.push_back(e);
    endfunction

    function automatic int model_winner();
        for (int r = 0; r < 3; r++)
            if (m_board[r*3+1] != 0 && m_board[r*3+1] == m_board[r*3+2] && m_board[r*3+1] == m_board[r*3+3])
                return m_board[r*3+1];
        for (int c = 1; c <= 3; c++)
            if (m_board[c] != 0 && m_board[c] == m_board[c+3] && m_board[c] == m_board[c+6])
                return m_board[c];
        if (m_board[5] != 0 && m_board[1] == m_board[5] && m_board[9] == m_board[5]) return m_board[5];
        if (m_board[5] != 0 && m_board[3] == m_board[5] && m_board[7] == m_board[5]) return m_board[5];
        return 0;
    endfunction

    task automatic model_new_game(bit toggle);
        for (int i = 1; i <= 9; i++) m_board[i] = 0;
        m_count = 0;
        m_over  = 1'b0;
        if (toggle && ALT) m_starter = ~m_starter;
        m_turn = m_starter;
    endtask

    task automatic take(int k);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", k, $time);
        end else begin
            e = q.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
            if (k == K_MARK) begin
                check("mark_idx", int'(bus.mark_idx), e.idx);
                check("mark_val", int'(bus.mark_val), e.val);
            end else if (k == K_ILL) begin
                check("illegal_turn", int'(bus.player_turn), e.turn);
            end else begin
                check("over_winner", int'(bus.winner), e.win);
                check("over_draw", int'(bus.draw), e.drw);
                check("over_count", int'(bus.move_count), e.cnt);
                check("over_turn", int'(bus.player_turn), e.turn);
            end
        end
    endtask

    bit go_prev = 1'b0;
    always @(negedge clk) begin
        if (!clr_n) begin
            go_prev = 1'b0;
        end else begin
            if (bus.mark_we) take(K_MARK);
            if (bus.illegal) take(K_ILL);
            if (bus.game_over && !go_prev) take(K_OVER);
            go_prev = bus.game_over;
        end
    end

    // mode 0: plain press; 1: extra press during COMMIT; 2: new_game during COMMIT
    task automatic do_press(int cur, int mode);
        bit legal;
        int c0;
        int w;
        legal = 1'b0;
        c0 = cyc;
        if (!m_over) begin
            if (cur >= 1 && cur <= 9 && m_board[cur] == 0) begin
                legal = 1'b1;
                m_board[cur] = m_turn ? 2 : 1;
                m_count++;
                push(K_MARK, cur, m_board[cur], 0, 0, 0, 0, c0 + 1);
                if (mode != 2) begin
                    w = model_winner();
                    if (w != 0 || m_count == 9) begin
                        m_over = 1'b1;
                        push(K_OVER, 0, 0, w, (w == 0) ? 1 : 0, m_count, int'(m_turn), c0 + 3);
                    end else begin
                        m_turn = ~m_turn;
                    end
                end
            end else begin
                push(K_ILL, 0, 0, 0, 0, 0, int'(m_turn), c0 + 1);
            end
        end
        bus.cursor = 4'(cur);
        bus.press  = 1'b1;
        @(posedge clk); #1;
        bus.press  = 1'b0;
        if (legal && mode == 1) begin
            bus.cursor = 4'($urandom_range(0, 15));
            bus.press  = 1'b1;
            @(posedge clk); #1;
            bus.press  = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end else if (legal && mode == 2) begin
            bus.new_game = 1'b1;
            @(posedge clk); #1;
            bus.new_game = 1'b0;
            model_new_game(1'b1);
            repeat (2) @(posedge clk);
            #1;
        end else begin
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic new_game_seq(bit with_press);
        bus.new_game = 1'b1;
        bus.press    = with_press;
        bus.cursor   = 4'($urandom_range(1, 9));
        @(posedge clk); #1;
        bus.new_game = 1'b0;
        bus.press    = 1'b0;
        model_new_game(1'b1);
        @(negedge clk);
        check("board_clr_on", int'(bus.board_clr), 1);
        @(negedge clk);
        check("board_clr_off", int'(bus.board_clr), 0);
        check("new_count", int'(bus.move_count), 0);
        check("new_turn", int'(bus.player_turn), int'(m_turn));
        check("new_game_over", int'(bus.game_over), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_mark_we"}, int'(bus.mark_we), 0);
        check({tag, "_board_clr"}, int'(bus.board_clr), 1);
        check({tag, "_illegal"}, int'(bus.illegal), 0);
        check({tag, "_game_over"}, int'(bus.game_over), 0);
        check({tag, "_draw"}, int'(bus.draw), 0);
        check({tag, "_turn"}, int'(bus.player_turn), int'(FP));
        check({tag, "_count"}, int'(bus.move_count), 0);
        check({tag, "_winner"}, int'(bus.winner), 0);
        check({tag, "_mark_idx"}, int'(bus.mark_idx), 0);
        check({tag, "_mark_val"}, int'(bus.mark_val), 0);
    endtask

    initial begin
        int draw_seq[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        int col_seq[6]  = '{1, 3, 2, 6, 4, 9};
        int mode;
        int cur;
        int presses;

        bus.press = 1'b0;
        bus.new_game = 1'b0;
        bus.cursor = 4'd0;
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        m_starter = FP;
        model_new_game(1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_clr", int'(bus.board_clr), 0);

        // Diagonal win for P1 with rejected presses mid-game.
        do_press(1, 0);
        do_press(2, 0);
        do_press(5, 0);
        check("turn_before_illegal", int'(bus.player_turn), 1);
        do_press(5, 0);
        do_press(0, 0);
        do_press(12, 0);
        check("turn_after_illegal", int'(bus.player_turn), 1);
        do_press(3, 0);
        do_press(9, 0);
        check("g1_over", int'(bus.game_over), 1);
        check("g1_winner", int'(bus.winner), 1);
        check("g1_count", int'(bus.move_count), 5);

        // Press ignored in GAME_OVER, then press+new_game together.
        do_press(4, 0);
        new_game_seq(1'b1);

        for (int i = 0; i < 9; i++) do_press(draw_seq[i], 0);
        check("draw_flag", int'(bus.draw), 1);
        check("draw_winner", int'(bus.winner), 0);
        check("draw_count", int'(bus.move_count), 9);
        check("draw_over", int'(bus.game_over), 1);

        new_game_seq(1'b0);
        for (int i = 0; i < 6; i++) do_press(col_seq[i], 0);
        check("col_winner", int'(bus.winner), 2);
        check("col_turn", int'(bus.player_turn), 1);

        // Async reset in the middle of COMMIT.
        new_game_seq(1'b0);
        bus.cursor = 4'd5;
        bus.press = 1'b1;
        @(posedge clk); #2;
        bus.press = 1'b0;
        check("commit_mark_we", int'(bus.mark_we), 1);
        clr_n = 1'b0;
        #1;
        check_reset_outputs("async");
        m_starter = FP;
        model_new_game(1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk); #1;

        for (int g = 0; g < 12; g++) begin
            presses = 0;
            while (!m_over && presses < 30) begin
                mode = $urandom_range(0, 19);
                mode = (mode == 18) ? 1 : (mode == 19) ? 2 : 0;
                cur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 9));
                do_press(cur, mode);
                presses++;
            end
            if ($urandom_range(0, 1) == 1) do_press(int'($urandom_range(0, 15)), 0);
            new_game_seq(1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
